// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// chunked_serial_adder : WIDTH-bit add/sub, CHUNK bits per clock, LSB first
// Revision 1.0
// ============================================================================
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;
  logic [CHUNK-1:0] w_ach;
  logic [CHUNK-1:0] w_bch;
  logic [CHUNK:0]   w_sum;
  logic             w_cmsb;
  logic             w_accept;
  logic             w_last;

  // Latched operands shift right each chunk, so the active chunk is always the low slice.
  assign w_ach  = r_a[CHUNK-1:0];
  assign w_bch  = r_b[CHUNK-1:0];
  assign w_sum  = {1'b0, w_ach} + {1'b0, w_bch} + {{CHUNK{1'b0}}, r_carry};
  assign w_cmsb = w_ach[CHUNK-1] ^ w_bch[CHUNK-1] ^ w_sum[CHUNK-1];
  assign w_last = (r_idx == IW'(NCHUNK - 1));

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
          w_idx_next   = '0;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + IW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub ? 1'b1 : cin;
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> CHUNK;
        r_b     <= r_b >> CHUNK;
        r_carry <= w_sum[CHUNK];
        for (int g = 0; g < NCHUNK; g++) begin
          if (r_idx == IW'(g)) begin
            r_s[g*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
          end
        end
        if (w_last) begin
          r_cout <= w_sum[CHUNK];
          r_ovf  <= w_cmsb ^ w_sum[CHUNK];
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// tb_chunked_serial_adder : scoreboard bench over four adder configurations
// Revision 1.0
// ============================================================================
module tb_chunked_serial_adder;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start8 = 0, cin8 = 0, sub8 = 0, busy8, done8, cout8, ovf8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic        start32 = 0, cin32 = 0, sub32 = 0, busy32, done32, cout32, ovf32;
  logic [31:0] a32 = 0, b32 = 0, s32;
  logic       start41 = 0, cin41 = 0, sub41 = 0, busy41, done41, cout41, ovf41;
  logic [3:0] a41 = 0, b41 = 0, s41;
  logic       start44 = 0, cin44 = 0, sub44 = 0, busy44, done44, cout44, ovf44;
  logic [3:0] a44 = 0, b44 = 0, s44;

  exp_t q8[$], q32[$], q41[$], q44[$];

  chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8));
  chunked_serial_adder u32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .busy(busy32), .done(done32), .s(s32), .cout(cout32), .ovf(ovf32));
  chunked_serial_adder #(.WIDTH(4), .CHUNK(1)) u41 (
    .clk(clk), .rst(rst), .start(start41), .a(a41), .b(b41), .cin(cin41), .sub(sub41),
    .busy(busy41), .done(done41), .s(s41), .cout(cout41), .ovf(ovf41));
  chunked_serial_adder #(.WIDTH(4), .CHUNK(4)) u44 (
    .clk(clk), .rst(rst), .start(start44), .a(a44), .b(b44), .cin(cin44), .sub(sub44),
    .busy(busy44), .done(done44), .s(s44), .cout(cout44), .ovf(ovf44));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result and checks it plus latency.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) chk("dut8_spurious_done", 1, 0);
      else begin
        e = q8.pop_front();
        chk("dut8_s", 32'(s8), e.s); chk("dut8_cout", 32'(cout8), 32'(e.cout));
        chk("dut8_ovf", 32'(ovf8), 32'(e.ovf)); chk("dut8_latency", cyc - e.acc, 2);
      end
    end
    if (done32) begin
      if (q32.size() == 0) chk("dut32_spurious_done", 1, 0);
      else begin
        e = q32.pop_front();
        chk("dut32_s", s32, e.s); chk("dut32_cout", 32'(cout32), 32'(e.cout));
        chk("dut32_ovf", 32'(ovf32), 32'(e.ovf)); chk("dut32_latency", cyc - e.acc, 4);
      end
    end
    if (done41) begin
      if (q41.size() == 0) chk("dut41_spurious_done", 1, 0);
      else begin
        e = q41.pop_front();
        chk("dut41_s", 32'(s41), e.s); chk("dut41_cout", 32'(cout41), 32'(e.cout));
        chk("dut41_ovf", 32'(ovf41), 32'(e.ovf)); chk("dut41_latency", cyc - e.acc, 4);
      end
    end
    if (done44) begin
      if (q44.size() == 0) chk("dut44_spurious_done", 1, 0);
      else begin
        e = q44.pop_front();
        chk("dut44_s", 32'(s44), e.s); chk("dut44_cout", 32'(cout44), 32'(e.cout));
        chk("dut44_ovf", 32'(ovf44), 32'(e.ovf)); chk("dut44_latency", cyc - e.acc, 1);
      end
    end
  end

  // Each go task is entered at a falling edge and returns at the falling edge
  // of the done cycle, so consecutive calls run back-to-back.
  task automatic go8(input logic [7:0] ia, ib, input logic ic, isb,
                     input logic [7:0] es, input logic ec, eo);
    exp_t e; int nb;
    a8 = ia; b8 = ib; cin8 = ic; sub8 = isb; start8 = 1;
    @(posedge clk); #1; start8 = 0;
    e.s = 32'(es); e.cout = ec; e.ovf = eo; e.acc = cyc; q8.push_back(e);
    a8 = ~ia; b8 = ib ^ 8'h5A; cin8 = ~ic; sub8 = ~isb;
    nb = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (!busy8) break; nb++; end
    chk("dut8_busy_cycles", nb, 2);
  endtask

  task automatic go32(input logic [31:0] ia, ib, input logic ic, isb,
                      input logic [31:0] es, input logic ec, eo);
    exp_t e; int nb;
    a32 = ia; b32 = ib; cin32 = ic; sub32 = isb; start32 = 1;
    @(posedge clk); #1; start32 = 0;
    e.s = es; e.cout = ec; e.ovf = eo; e.acc = cyc; q32.push_back(e);
    a32 = ~ia; b32 = ib ^ 32'hDEADBEEF; cin32 = ~ic; sub32 = ~isb;
    nb = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (!busy32) break; nb++; end
    chk("dut32_busy_cycles", nb, 4);
  endtask

  task automatic go41(input logic [3:0] ia, ib, input logic ic, isb,
                      input logic [3:0] es, input logic ec, eo);
    exp_t e; int nb;
    a41 = ia; b41 = ib; cin41 = ic; sub41 = isb; start41 = 1;
    @(posedge clk); #1; start41 = 0;
    e.s = 32'(es); e.cout = ec; e.ovf = eo; e.acc = cyc; q41.push_back(e);
    a41 = ~ia; b41 = ~ib; cin41 = ~ic; sub41 = ~isb;
    nb = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (!busy41) break; nb++; end
    chk("dut41_busy_cycles", nb, 4);
  endtask

  task automatic go44(input logic [3:0] ia, ib, input logic ic, isb,
                      input logic [3:0] es, input logic ec, eo);
    exp_t e; int nb;
    a44 = ia; b44 = ib; cin44 = ic; sub44 = isb; start44 = 1;
    @(posedge clk); #1; start44 = 0;
    e.s = 32'(es); e.cout = ec; e.ovf = eo; e.acc = cyc; q44.push_back(e);
    a44 = ~ia; b44 = ~ib; cin44 = ~ic; sub44 = ~isb;
    nb = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (!busy44) break; nb++; end
    chk("dut44_busy_cycles", nb, 1);
  endtask

  // Reference for 4-bit ops from integer arithmetic: returns {ovf, cout, s}.
  function automatic logic [5:0] ref4(input int ai, bi, ci, si);
    int sa, sb, r, u;
    sa = (ai > 7) ? ai - 16 : ai;
    sb = (bi > 7) ? bi - 16 : bi;
    r  = si ? sa - sb : sa + sb + ci;
    u  = si ? ai + (15 - bi) + 1 : ai + bi + ci;
    ref4 = {(r > 7 || r < -8) ? 1'b1 : 1'b0, (u >= 16) ? 1'b1 : 1'b0, 4'(u)};
  endfunction

  task automatic sweep41();
    logic [5:0] r;
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          for (int si = 0; si < 2; si++) begin
            r = ref4(ai, bi, ci, si);
            go41(4'(ai), 4'(bi), ci[0], si[0], r[3:0], r[4], r[5]);
          end
  endtask

  task automatic sweep44();
    logic [5:0] r;
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          for (int si = 0; si < 2; si++) begin
            r = ref4(ai, bi, ci, si);
            go44(4'(ai), 4'(bi), ci[0], si[0], r[3:0], r[4], r[5]);
          end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    // Asynchronous reset before any clock edge.
    #2 rst = 1;
    #1;
    chk("rst_busy", 32'(busy8), 0); chk("rst_done", 32'(done8), 0);
    chk("rst_s", 32'(s8), 0); chk("rst_cout", 32'(cout8), 0); chk("rst_ovf", 32'(ovf8), 0);
    chk("rst_s32", s32, 0); chk("rst_busy32", 32'(busy32), 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // 8-bit, 4-bit chunks
    go8(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    go8(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
    go8(8'h05, 8'h07, 0, 1, 8'hFE, 0, 0);
    go8(8'h80, 8'h01, 0, 1, 8'h7F, 1, 1);
    go8(8'h10, 8'h10, 1, 1, 8'h00, 1, 0);
    go8(8'h3C, 8'h45, 1, 0, 8'h82, 0, 1);
    // Asynchronous reset mid-cycle clears the held result and the done pulse.
    #2 rst = 1;
    #1;
    chk("rst2_s", 32'(s8), 0); chk("rst2_ovf", 32'(ovf8), 0);
    chk("rst2_done", 32'(done8), 0); chk("rst2_busy", 32'(busy8), 0);
    @(negedge clk);
    rst = 0;

    // 32-bit: start held for 5 edges yields a single operation.
    a32 = 32'h12345678; b32 = 32'h11111111; cin32 = 0; sub32 = 0; start32 = 1;
    @(posedge clk); #1;
    e.s = 32'h23456789; e.cout = 0; e.ovf = 0; e.acc = cyc; q32.push_back(e);
    a32 = 32'hCAFEF00D; b32 = 32'h0BADBEEF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("hold_done_cycle", 32'(done32), 1);
    // Start on the done cycle with new operands.
    go32(32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0);
    go32(32'h0000FFFF, 32'h0000FFFF, 1, 0, 32'h0001FFFF, 0, 0);

    // Abort after two chunks: no done, outputs cleared at once.
    a32 = 32'hAAAAAAAA; b32 = 32'h11111111; cin32 = 0; sub32 = 0; start32 = 1;
    @(posedge clk); #1; start32 = 0;
    @(posedge clk); @(posedge clk); #2;
    chk("abort_partial_s", 32'(s32 != 0), 1);
    rst = 1;
    #1;
    chk("abort_busy", 32'(busy32), 0); chk("abort_s", s32, 0); chk("abort_done", 32'(done32), 0);
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    go32(32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1);

    // Exhaustive 4-bit, bit-serial and single-cycle, in parallel.
    fork
      sweep41();
      sweep44();
    join

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q32_drained", q32.size(), 0);
    chk("q41_drained", q41.size(), 0);
    chk("q44_drained", q44.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle parametrised adder/subtractor built on the full-adder datapath.
- Adds two WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, with the carry held in a register between chunks.
- Uses start/busy/done handshake; reports sum, carry-out and signed overflow.
- Trades latency for a narrow CHUNK-bit adder; used where the datapath is wide but an add need not finish in one cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived local constant (not overridable); cycles per operation.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request; sampled only while idle.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- cin  in  1  carry-in for add; captured with operands; ignored when sub=1.
- sub  in  1  1 = compute a - b (a + ~b + 1); captured with operands.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; result valid.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out of bit WIDTH-1; for sub, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, any time):
  - busy=0, done=0, s=0, cout=0, ovf=0.
  - Chunk index=0; carry register=0; state=IDLE.
  - An operation in progress is aborted and no done is produced.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE to RUN: start=1 at a rising edge (edge E0).
  - Latch a, b (b inverted when sub=1).
  - Carry register = (sub ? 1 : cin).
  - Index = 0.
- RUN:
  - At each edge Ek (k=1..NCHUNK), the adder processes chunk k-1: bits [(k-1)*CHUNK +: CHUNK] of the latched operands plus the carry register.
  - The result is written into the same slice of s, and the carry register is updated.
  - At edge E_NCHUNK:
    - cout = final carry.
    - ovf = carry into MSB XOR final carry.
    - State returns to IDLE; busy falls.
    - done rises for exactly one cycle.
- Latency: done is high in the cycle following edge E_NCHUNK (NCHUNK cycles after acceptance). For CHUNK=WIDTH, latency is 1.
- start while busy=1: ignored; operands and state are unaffected.
- start during the done cycle: accepted (state is IDLE).
  - done drops at the next edge.
  - A new operation runs back-to-back with no bubble.
- s, cout, ovf:
  - Hold the last result from done until the next accepted start.
  - During RUN, s holds partially updated chunks and is not valid.
  - cout and ovf are not updated until E_NCHUNK.
- Operand inputs may change freely after acceptance without affecting the result.
- The result is modulo 2^WIDTH; no saturation.

Test Plan:
- Reset, WIDTH=8, CHUNK=4: assert rst mid-cycle with no clock edge -> busy=0, done=0, s=8'h00, cout=0, ovf=0 immediately.
- Add with carry wrap, WIDTH=8, CHUNK=4: a=8'hFF, b=8'h01, cin=0, start -> busy=1 for 2 cycles, done pulse 2 cycles after accept, s=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01 -> s=8'h80, cout=0, ovf=1.
- Subtract, WIDTH=8, CHUNK=4:
  - 8'h05-8'h07 -> s=8'hFE, cout=0, ovf=0.
  - 8'h80-8'h01 -> s=8'h7F, cout=1, ovf=1.
  - With sub=1 and cin=1, 8'h10-8'h10 -> s=8'h00, cout=1 (cin ignored).
- Handshake: start held high for 5 cycles at defaults (32/8) -> exactly one operation runs, done after 4 cycles. Then start asserted on the done cycle with new operands -> second done exactly 4 cycles later with the correct sum. Operands changed while busy -> result unaffected.
- Reset mid-operation, defaults: rst pulsed after 2 of 4 chunks -> busy=0 and s=0 immediately, no done pulse; the next start completes normally.
- Exhaustive, WIDTH=4, CHUNK=1 and WIDTH=4, CHUNK=4: all a, b, cin, sub combinations (1024) -> {cout,s} equals a+b+cin (add) or a+~b+1 (sub), ovf matches the signed reference, and latency is 4 and 1 cycles respectively.
